// File: rtl/mult_feed_if.sv
// Bundle of the operand push, multiplier and result pop signals around mult_feed_seq.
// master = environment side (operand source, multiplier, result sink); slave = mult_feed_seq.
interface mult_feed_if #(
    parameter int M_bits = 12,
    parameter int N_bits = 8,
    parameter int DEPTH  = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [M_bits-1:0]          in_mpd;
    logic [N_bits-1:0]          in_mpr;
    logic [M_bits-1:0]          mpd;
    logic [N_bits-1:0]          mpr;
    logic                       start;
    logic                       busy;
    logic [M_bits+N_bits-1:0]   prod;
    logic                       res_valid;
    logic                       res_ready;
    logic [M_bits+N_bits-1:0]   res_prod;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output in_valid, in_mpd, in_mpr, busy, prod, res_ready,
        input  in_ready, mpd, mpr, start, res_valid, res_prod, count
    );

    modport slave (
        input  in_valid, in_mpd, in_mpr, busy, prod, res_ready,
        output in_ready, mpd, mpr, start, res_valid, res_prod, count
    );
endinterface

// File: rtl/mult_feed_seq.sv
// Operand FIFO feeding an external sequential multiplier, one product in flight at a time.
// Define MULT_FEED_ZERO_BYPASS_EN to answer zero-operand pairs without using the multiplier.
module mult_feed_seq #(
    parameter int M_bits = 12,
    parameter int N_bits = 8,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    mult_feed_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = M_bits + N_bits;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [M_bits-1:0] mem_mpd [DEPTH];
    logic [N_bits-1:0] mem_mpr [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_r;
    logic              wait_cnt;
    logic [M_bits-1:0] mpd_r;
    logic [N_bits-1:0] mpr_r;
    logic [PW-1:0]     res_prod_r;
    logic              res_valid_r;
    logic              push;
    logic              can_issue;
    logic              head_zero;
    logic              pop;
    logic              start_c;
    logic              cap_prod;
    logic              cap_zero;
    logic              res_clr;

    assign bus.in_ready  = (count_r != CW'(DEPTH));
    assign bus.count     = count_r;
    assign bus.mpd       = mpd_r;
    assign bus.mpr       = mpr_r;
    assign bus.start     = start_c;
    assign bus.res_valid = res_valid_r;
    assign bus.res_prod  = res_prod_r;

    assign push      = bus.in_valid && bus.in_ready;
    assign can_issue = (count_r != '0) && !bus.busy;

`ifdef MULT_FEED_ZERO_BYPASS_EN
    assign head_zero = (mem_mpd[rd_ptr] == '0) || (mem_mpr[rd_ptr] == '0);
`else
    assign head_zero = 1'b0;
`endif

    // Operand storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem_mpd[wr_ptr] <= bus.in_mpd;
            mem_mpr[wr_ptr] <= bus.in_mpr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT_HI);
        end
    end

    // A multiplier that never raises busy is taken as done after two WAIT_HI cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_issue) state_nxt = head_zero ? HOLD : ISSUE;
            ISSUE:   state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (bus.busy)    state_nxt = WAIT_LO;
                else if (wait_cnt) state_nxt = HOLD;
            end
            WAIT_LO: if (!bus.busy) state_nxt = HOLD;
            HOLD:    if (res_valid_r && bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        start_c  = 1'b0;
        cap_prod = 1'b0;
        cap_zero = 1'b0;
        res_clr  = 1'b0;
        case (state)
            IDLE: begin
                pop      = can_issue;
                cap_zero = can_issue && head_zero;
            end
            ISSUE:   start_c  = 1'b1;
            WAIT_HI: cap_prod = !bus.busy && wait_cnt;
            WAIT_LO: cap_prod = !bus.busy;
            HOLD:    res_clr  = res_valid_r && bus.res_ready;
            default: ;
        endcase
    end

    // Operand and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mpd_r       <= '0;
            mpr_r       <= '0;
            res_prod_r  <= '0;
            res_valid_r <= 1'b0;
        end else begin
            if (pop) begin
                mpd_r <= mem_mpd[rd_ptr];
                mpr_r <= mem_mpr[rd_ptr];
            end
            if (cap_prod) begin
                res_prod_r  <= bus.prod;
                res_valid_r <= 1'b1;
            end else if (cap_zero) begin
                res_prod_r  <= '0;
                res_valid_r <= 1'b1;
            end else if (res_clr) begin
                res_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_feed_seq.sv
// Self-checking bench for mult_feed_seq with a behavioural multiplier and a product queue model.
module tb_mult_feed_seq;
    localparam int MW = 12;
    localparam int NW = 8;
    localparam int DP = 4;
    localparam int PW = MW + NW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;
    bit   force_busy = 1'b0;
    int   lat_lo = 1;
    int   lat_hi = 1;
    int   mul_left = 0;
    logic [MW-1:0] mul_a;
    logic [NW-1:0] mul_b;

    mult_feed_if #(.M_bits(MW), .N_bits(NW), .DEPTH(DP)) bus ();

    mult_feed_seq #(.M_bits(MW), .N_bits(NW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

    // Behavioural multiplier: latency 0 means busy never rises and prod is ready at once.
    initial begin
        bus.busy = 1'b0;
        bus.prod = '0;
        forever begin
            @(negedge clk);
            if (bus.start === 1'b1) starts++;
            if (force_busy) begin
                bus.busy = 1'b1;
            end else if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    bus.busy = 1'b0;
                    bus.prod = PW'(mul_a) * PW'(mul_b);
                end
            end else begin
                bus.busy = 1'b0;
            end
            if (bus.start === 1'b1) begin
                mul_a    = bus.mpd;
                mul_b    = bus.mpr;
                mul_left = $urandom_range(lat_hi, lat_lo);
                if (mul_left == 0) begin
                    bus.prod = PW'(mul_a) * PW'(mul_b);
                end else begin
                    bus.busy = 1'b1;
                    bus.prod = PW'($urandom);
                end
            end
        end
    end

    task automatic push_pair(input logic [MW-1:0] a, input logic [NW-1:0] b, output bit ok);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_mpd   = a;
        bus.in_mpr   = b;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.in_ready === 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input int max_cyc, output logic [PW-1:0] r, output bit ok);
        int n = 0;
        bus.res_ready = 1'b1;
        while (bus.res_valid !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.res_valid === 1'b1);
        r  = bus.res_prod;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", bus.start); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
        checks++; if (bus.res_prod !== 20'h0) begin errors++; $display("FAIL reset_res_prod got %h want 0", bus.res_prod); end
        checks++; if (bus.mpd !== 12'h0 || bus.mpr !== 8'h0) begin errors++; $display("FAIL reset_operands got %h/%h want 0/0", bus.mpd, bus.mpr); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single();
        int s0;
        bit ok_p, ok_r;
        logic [PW-1:0] r;
        lat_lo = 3; lat_hi = 3;
        s0 = starts;
        push_pair(12'hFFF, 8'hFF, ok_p);
        get_result(100, r, ok_r);
        checks++; if (!ok_p || !ok_r || r !== 20'hFEF01) begin errors++; $display("FAIL single_prod got %h want fef01 (push %b res %b)", r, ok_p, ok_r); end
        repeat (6) @(negedge clk);
        checks++; if (starts - s0 != 1) begin errors++; $display("FAIL single_starts got %0d want 1", starts - s0); end
    endtask

    task automatic test_fill();
        int s0;
        int pushed = 0;
        bit ok;
        logic [MW-1:0] a;
        logic [NW-1:0] b;
        logic [PW-1:0] r;
        logic [PW-1:0] exp_q[$];
        force_busy = 1'b1;
        lat_lo = 2; lat_hi = 2;
        repeat (2) @(negedge clk);
        s0 = starts;
        for (int i = 0; i < 4; i++) begin
            a = MW'($urandom_range(1, 4095));
            b = NW'($urandom_range(1, 255));
            push_pair(a, b, ok);
            if (ok) begin
                pushed++;
                exp_q.push_back(PW'(a) * PW'(b));
            end
        end
        checks++; if (pushed != 4) begin errors++; $display("FAIL fill_pushes got %0d want 4", pushed); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", bus.count); end
        bus.in_valid = 1'b1;
        bus.in_mpd   = MW'($urandom_range(1, 4095));
        bus.in_mpr   = NW'($urandom_range(1, 255));
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_overflow_count got %0d want 4", bus.count); end
        checks++; if (starts != s0) begin errors++; $display("FAIL fill_no_start got %0d want 0", starts - s0); end
        force_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            get_result(100, r, ok);
            checks++;
            if (!ok || exp_q.size() == 0 || r !== exp_q[0]) begin
                errors++;
                $display("FAIL fill_drain_%0d got %h want %h", i, r, (exp_q.size() != 0) ? exp_q[0] : 20'h0);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL fill_empty_count got %0d want 0", bus.count); end
    endtask

    task automatic test_backpressure();
        int s0;
        int n = 0;
        bit ok1, ok2, ok;
        logic [MW-1:0] a2;
        logic [NW-1:0] b2;
        logic [PW-1:0] e1;
        logic [PW-1:0] r;
        lat_lo = 2; lat_hi = 2;
        s0 = starts;
        e1 = PW'(12'h7DF) * PW'(8'h77);
        a2 = MW'($urandom_range(1, 4095));
        b2 = NW'($urandom_range(1, 255));
        push_pair(12'h7DF, 8'h77, ok1);
        push_pair(a2, b2, ok2);
        while (bus.res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_prod !== e1) begin
                errors++;
                $display("FAIL bp_hold_%0d got %b/%h want 1/%h", i, bus.res_valid, bus.res_prod, e1);
            end
            @(negedge clk);
        end
        checks++; if (starts - s0 != 1) begin errors++; $display("FAIL bp_starts got %0d want 1", starts - s0); end
        get_result(5, r, ok);
        checks++; if (!ok1 || !ok || r !== e1) begin errors++; $display("FAIL bp_first got %h want %h", r, e1); end
        get_result(100, r, ok);
        checks++; if (!ok2 || !ok || r !== PW'(a2) * PW'(b2)) begin errors++; $display("FAIL bp_second got %h want %h", r, PW'(a2) * PW'(b2)); end
    endtask

    task automatic test_zero();
        logic [MW-1:0] za [2];
        logic [NW-1:0] zb [2];
        int s0;
        bit ok_p, ok;
        logic [PW-1:0] r;
        za[0] = 12'h000; zb[0] = 8'h00;
        za[1] = 12'h5A3; zb[1] = 8'h00;
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 2; i++) begin
            s0 = starts;
            push_pair(za[i], zb[i], ok_p);
`ifdef MULT_FEED_ZERO_BYPASS_EN
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL zero_early_%0d got %b want 0", i, bus.res_valid); end
            @(negedge clk);
            checks++; if (bus.res_valid !== 1'b1 || bus.res_prod !== 20'h0) begin errors++; $display("FAIL zero_bypass_%0d got %b/%h want 1/0", i, bus.res_valid, bus.res_prod); end
`endif
            get_result(100, r, ok);
            checks++; if (!ok_p || !ok || r !== 20'h0) begin errors++; $display("FAIL zero_prod_%0d got %h want 0", i, r); end
            repeat (4) @(negedge clk);
`ifdef MULT_FEED_ZERO_BYPASS_EN
            checks++; if (starts != s0) begin errors++; $display("FAIL zero_starts_%0d got %0d want 0", i, starts - s0); end
`else
            checks++; if (starts - s0 != 1) begin errors++; $display("FAIL zero_starts_%0d got %0d want 1", i, starts - s0); end
`endif
        end
    endtask

    task automatic test_mid_reset();
        int s0;
        bit ok;
        bit seen = 1'b0;
        lat_lo = 25; lat_hi = 25;
        s0 = starts;
        for (int i = 0; i < 4; i++) begin
            push_pair(MW'($urandom_range(1, 4095)), NW'($urandom_range(1, 255)), ok);
        end
        repeat (2) @(negedge clk);
        checks++; if (bus.count !== 3'd3 || bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_setup got count %0d busy %b want 3/1", bus.count, bus.busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", bus.count); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL midrst_res_valid got %b want 0", bus.res_valid); end
        bus.res_ready = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) seen = 1'b1;
        end
        bus.res_ready = 1'b0;
        checks++; if (seen) begin errors++; $display("FAIL midrst_stale_result got 1 want 0"); end
        checks++; if (starts - s0 != 1) begin errors++; $display("FAIL midrst_starts got %0d want 1", starts - s0); end
    endtask

    task automatic test_ordering();
        logic [MW-1:0] oa [3];
        logic [NW-1:0] ob [3];
        int s0;
        bit ok;
        logic [PW-1:0] r;
        oa[0] = 12'h6DD; ob[0] = 8'hFF;
        oa[1] = 12'h8B7; ob[1] = 8'h1F;
        oa[2] = 12'hAAB; ob[2] = 8'hDF;
        lat_lo = 0; lat_hi = 4;
        s0 = starts;
        for (int i = 0; i < 3; i++) push_pair(oa[i], ob[i], ok);
        for (int i = 0; i < 3; i++) begin
            get_result(100, r, ok);
            checks++;
            if (!ok || r !== PW'(oa[i]) * PW'(ob[i])) begin
                errors++;
                $display("FAIL order_%0d got %h want %h", i, r, PW'(oa[i]) * PW'(ob[i]));
            end
        end
        checks++; if (starts - s0 != 3) begin errors++; $display("FAIL order_starts got %0d want 3", starts - s0); end
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic [PW-1:0] exp_q[$];
        int got = 0;
        lat_lo = 0; lat_hi = 5;
        fork
            begin
                bit ok;
                logic [MW-1:0] a;
                logic [NW-1:0] b;
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    a = ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom);
                    b = ($urandom_range(0, 7) == 0) ? '0 : NW'($urandom);
                    push_pair(a, b, ok);
                    checks++;
                    if (!ok) begin errors++; $display("FAIL rand_push_%0d got in_ready 0 want 1", i); end
                    else exp_q.push_back(PW'(a) * PW'(b));
                end
            end
            begin
                int cyc = 0;
                bit rdy;
                while (got < N && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    rdy = ($urandom_range(0, 3) != 0);
                    bus.res_ready = rdy;
                    if (rdy && bus.res_valid === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_result_%0d got %h want none", got, bus.res_prod);
                        end else if (bus.res_prod !== exp_q[0]) begin
                            errors++;
                            $display("FAIL rand_result_%0d got %h want %h", got, bus.res_prod, exp_q[0]);
                        end
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        got++;
                    end
                end
                @(negedge clk);
                bus.res_ready = 1'b0;
            end
        join
        checks++; if (got != N) begin errors++; $display("FAIL rand_count got %0d want %0d", got, N); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mpd    = '0;
        bus.in_mpr    = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_zero();
        test_mid_reset();
        test_ordering();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
